transmisor_dato: RTL and testbench

Host-to-device PS/2 transmitter: sends one command byte (e.g. LED set 0xED, reset 0xFF) from the FPGA to a PS/2 keyboard/mouse on the Nexys board. It runs the full host request-to-send sequence, shifts 8 data bits plus odd parity and stop on device-generated clock edges, and checks the device ACK. It shares the ps2c/ps2d lines with the PS/2 receive path, which must be gated off while `tx_idle` is low.

---
 rtl/transmisor_dato_pkg.sv | 28 ++
 rtl/transmisor_dato_if.sv | 22 ++
 rtl/transmisor_dato_ps2c_filtro.sv | 41 ++++
 rtl/transmisor_dato.sv | 146 ++++++++++++++
 tb/tb_transmisor_dato.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/transmisor_dato_pkg.sv
// Shared types and defaults for the PS/2 host-to-device transmitter.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package transmisor_dato_pkg;

  // Transmitter FSM states, in the order a frame walks through them
  typedef enum logic [2:0] {
    idle,
    rts,
    start,
    data,
    stop,
    ack
  } state_t;

  // 120 us request-to-send hold at 100 MHz
  localparam int RTS_CYCLES_DEF     = 12000;
  // 20 ms between device clock falling edges before giving up
  localparam int TIMEOUT_CYCLES_DEF = 2000000;
  // Taps in the ps2c glitch filter
  localparam int FILTRO_LEN         = 8;

  // Frame as shifted out: odd parity above the data byte, bit 0 goes first
  function automatic logic [8:0] frame_de(input logic [7:0] b);
    return {~^b, b};
  endfunction

endpackage

// File: rtl/transmisor_dato_if.sv
// Command-side handshake between a requester and the PS/2 transmitter.
// Latency: n/a (wires only).
// Backpressure: requester may strobe wr_ps2 only while tx_idle is high.
interface transmisor_dato_if;

  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err_tick;

  modport master (
    output wr_ps2, din,
    input  tx_idle, tx_done_tick, tx_err_tick
  );

  modport slave (
    input  wr_ps2, din,
    output tx_idle, tx_done_tick, tx_err_tick
  );

endinterface

// File: rtl/transmisor_dato_ps2c_filtro.sv
// Debounces the raw PS/2 clock and flags its filtered falling edges.
// Latency: filtered level follows a stable raw level after FILTRO_LEN cycles.
// Backpressure: none; free-running, one sample per clk_nexys cycle.
module ps2c_filtro
  import transmisor_dato_pkg::*;
(
  input  logic clk_nexys,
  input  logic reset,
  input  logic ps2c_raw,
  output logic ps2c_filt,
  output logic fall_edge
);

  logic [FILTRO_LEN-1:0] filter_reg, filter_next;
  logic                  f_reg, f_next;

  // Sample history and filtered level; both start low so a high idle line is not an edge
  always_ff @(posedge clk_nexys or posedge reset) begin
    if (reset) begin
      filter_reg <= '0;
      f_reg      <= 1'b0;
    end else begin
      filter_reg <= filter_next;
      f_reg      <= f_next;
    end
  end

  // Newest sample enters at the MSB; level only changes on a unanimous history
  always_comb begin
    filter_next = {ps2c_raw, filter_reg[FILTRO_LEN-1:1]};
    f_next      = f_reg;
    if (&filter_reg)
      f_next = 1'b1;
    else if (~|filter_reg)
      f_next = 1'b0;
  end

  assign ps2c_filt = f_reg;
  assign fall_edge = f_reg & ~f_next;

endmodule

// File: rtl/transmisor_dato.sv
// Sends one command byte to a PS/2 device: request-to-send, 8 data + odd parity + stop, ACK check.
// Latency: tx_idle falls the cycle after the strobe; done/err tick when the FSM returns to idle.
// Backpressure: strobes are taken only in idle; wr_ps2 is ignored while a frame is in flight.
module transmisor_dato
  import transmisor_dato_pkg::*;
#(
  parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clk_nexys,
  input  logic             reset,
  transmisor_dato_if.slave tx,
  inout  wire              ps2c,
  inout  wire              ps2d
);

  localparam int CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [8:0]       frame_reg, frame_next;
  logic [3:0]       n_reg, n_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             c_en, d_en;
  logic             fall_edge;
  logic             ps2c_filt;

  ps2c_filtro u_filtro (
    .clk_nexys (clk_nexys),
    .reset     (reset),
    .ps2c_raw  (ps2c),
    .ps2c_filt (ps2c_filt),
    .fall_edge (fall_edge)
  );

  // FSM state, shift frame, bit counter, cycle counter and registered result ticks
  always_ff @(posedge clk_nexys or posedge reset) begin
    if (reset) begin
      state_reg <= idle;
      frame_reg <= '0;
      n_reg     <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      frame_reg <= frame_next;
      n_reg     <= n_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // Next-state, line enables and result ticks; edges in idle/rts are our own and ignored
  always_comb begin
    state_next = state_reg;
    frame_next = frame_reg;
    n_next     = n_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    c_en       = 1'b0;
    d_en       = 1'b0;

    case (state_reg)
      idle: begin
        if (tx.wr_ps2) begin
          frame_next = frame_de(tx.din);
          cnt_next   = '0;
          state_next = rts;
        end
      end
      rts: begin
        // Clock held low to request the bus; data low doubles as the start bit
        c_en = 1'b1;
        d_en = 1'b1;
        if (cnt_reg == RTS_LAST) begin
          cnt_next   = '0;
          state_next = start;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      start: begin
        d_en = 1'b1;
        if (fall_edge) begin
          n_next     = 4'd8;
          cnt_next   = '0;
          state_next = data;
        end
      end
      data: begin
        d_en = ~frame_reg[0];
        if (fall_edge) begin
          cnt_next = '0;
          if (n_reg == 4'd0) begin
            state_next = stop;
          end else begin
            frame_next = {1'b0, frame_reg[8:1]};
            n_next     = n_reg - 1'b1;
          end
        end
      end
      stop: begin
        if (fall_edge) begin
          cnt_next   = '0;
          state_next = ack;
        end
      end
      ack: begin
        // Entered right after the 11th filtered edge; the device is still
        // holding data low for ACK in that clock-low phase, so read it now
        if (ps2d == 1'b0)
          done_next = 1'b1;
        else
          err_next = 1'b1;
        state_next = idle;
      end
      default: state_next = idle;
    endcase

    // A device that stops clocking must not hold the bus forever
    if ((state_reg == start || state_reg == data || state_reg == stop) && !fall_edge) begin
      if (cnt_reg == TMO_LAST) begin
        err_next   = 1'b1;
        state_next = idle;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  // Open-drain: only ever pull low, otherwise let the pull-ups win
  assign ps2c = c_en ? 1'b0 : 1'bz;
  assign ps2d = d_en ? 1'b0 : 1'bz;

  assign tx.tx_idle      = (state_reg == idle);
  assign tx.tx_done_tick = done_reg;
  assign tx.tx_err_tick  = err_reg;

endmodule

// File: tb/tb_transmisor_dato.sv
// Directed bench for transmisor_dato with a behavioural PS/2 device model.
// Latency: n/a.
// Backpressure: n/a.
module tb_transmisor_dato;
  import transmisor_dato_pkg::*;

  localparam int RTS  = 200;
  localparam int TMO  = 3000;
  localparam int HALF = 40;

  logic clk_nexys = 1'b0;
  logic reset     = 1'b1;
  logic dev_c_low = 1'b0;
  logic dev_d_low = 1'b0;
  wire  ps2c;
  wire  ps2d;

  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;
  pullup (ps2c);
  pullup (ps2d);

  transmisor_dato_if bus ();

  transmisor_dato #(
    .RTS_CYCLES     (RTS),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_nexys (clk_nexys),
    .reset     (reset),
    .tx        (bus),
    .ps2c      (ps2c),
    .ps2d      (ps2d)
  );

  always #5 clk_nexys = ~clk_nexys;

  int checks    = 0;
  int failures  = 0;
  int done_seen = 0;
  int err_seen  = 0;

  always @(negedge clk_nexys) begin
    if (bus.tx_done_tick === 1'b1) done_seen <= done_seen + 1;
    if (bus.tx_err_tick === 1'b1)  err_seen  <= err_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_nexys);
  endtask

  // One device clock pulse; data is read at the end of the low phase
  task automatic pulse(input bit ack_low, output logic s);
    if (ack_low) dev_d_low = 1'b1;
    dev_c_low = 1'b1;
    cyc(HALF);
    s = ps2d;
    dev_c_low = 1'b0;
    cyc(HALF);
    dev_d_low = 1'b0;
  endtask

  // Strobe a byte, check the request-to-send, then clock npulses from the device
  task automatic frame(input logic [7:0] b, input int npulses, input bit give_ack,
                       input bit poke, output logic [9:0] word);
    int   low;
    logic s;
    word = '0;
    @(negedge clk_nexys);
    bus.wr_ps2 = 1'b1;
    bus.din    = b;
    @(negedge clk_nexys);
    bus.wr_ps2 = 1'b0;
    chk("tx_idle_low", 32'(bus.tx_idle), 32'd0);
    low = 0;
    while (ps2c === 1'b0 && low < RTS + 50) begin
      low++;
      @(negedge clk_nexys);
    end
    chk("rts_len", 32'(low), 32'(RTS));
    chk("start_bit", 32'(ps2d), 32'd0);
    cyc(HALF);
    for (int i = 0; i < npulses; i++) begin
      if (poke && i == 3) begin
        bus.wr_ps2 = 1'b1;
        bus.din    = 8'hFF;
        @(negedge clk_nexys);
        bus.wr_ps2 = 1'b0;
      end
      pulse(give_ack && (i == 10), s);
      if (i < 10) word[i] = s;
    end
  endtask

  initial begin
    logic [9:0] w;
    int         t;
    bus.wr_ps2 = 1'b0;
    bus.din    = 8'h00;

    // Reset state
    cyc(3);
    chk("rst_ps2c", 32'(ps2c), 32'd1);
    chk("rst_ps2d", 32'(ps2d), 32'd1);
    chk("rst_idle", 32'(bus.tx_idle), 32'd1);
    chk("rst_done", 32'(bus.tx_done_tick), 32'd0);
    chk("rst_err", 32'(bus.tx_err_tick), 32'd0);
    reset = 1'b0;

    // Quiet idle
    cyc(1000);
    chk("idle_done", 32'(done_seen), 32'd0);
    chk("idle_err", 32'(err_seen), 32'd0);
    chk("idle_flag", 32'(bus.tx_idle), 32'd1);
    chk("idle_ps2c", 32'(ps2c), 32'd1);

    // 0xED with ACK: d0..d7 = 1,0,1,1,0,1,1,1, parity 1, stop 1
    frame(8'hED, 11, 1'b1, 1'b0, w);
    cyc(20);
    chk("bits_ed", 32'(w), 32'h3ED);
    chk("done_ed", 32'(done_seen), 32'd1);
    chk("err_ed", 32'(err_seen), 32'd0);
    chk("idle_ed", 32'(bus.tx_idle), 32'd1);

    // 0x00 without ACK: parity 1, error tick
    frame(8'h00, 11, 1'b0, 1'b0, w);
    cyc(20);
    chk("bits_00", 32'(w), 32'h300);
    chk("err_noack", 32'(err_seen), 32'd1);
    chk("done_noack", 32'(done_seen), 32'd1);

    // Device stops after 4 edges: d3 of 0x55 (a 0) is on the line, then timeout
    frame(8'h55, 4, 1'b0, 1'b0, w);
    chk("tmo_d3_low", 32'(ps2d), 32'd0);
    t = 0;
    while (err_seen == 1 && t < TMO + 500) begin
      cyc(1);
      t++;
    end
    chk("tmo_err", 32'(err_seen), 32'd2);
    chk("tmo_window", 32'((t > TMO - 200) && (t <= TMO)), 32'd1);
    chk("tmo_ps2c", 32'(ps2c), 32'd1);
    chk("tmo_ps2d", 32'(ps2d), 32'd1);
    chk("tmo_idle", 32'(bus.tx_idle), 32'd1);

    // Strobe of 0xFF mid-frame is ignored; 0x3C goes out (parity 1)
    frame(8'h3C, 11, 1'b1, 1'b1, w);
    cyc(20);
    chk("bits_poke", 32'(w), 32'h33C);
    chk("done_poke", 32'(done_seen), 32'd2);

    // Reset mid-data: d2 of 0xAB (a 0) on the line, released by reset at once
    frame(8'hAB, 3, 1'b0, 1'b0, w);
    chk("mid_d2_low", 32'(ps2d), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_ps2d", 32'(ps2d), 32'd1);
    chk("mid_rst_ps2c", 32'(ps2c), 32'd1);
    chk("mid_rst_idle", 32'(bus.tx_idle), 32'd1);
    cyc(2);
    reset = 1'b0;
    cyc(20);

    // 0xF4 after reset: parity 0
    frame(8'hF4, 11, 1'b1, 1'b0, w);
    cyc(20);
    chk("bits_f4", 32'(w), 32'h2F4);
    chk("done_f4", 32'(done_seen), 32'd3);
    chk("err_f4", 32'(err_seen), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
